// File: rtl/slice_pkg.sv
// ============================================================================
// Module  : slice_pkg
// Brief   : Shared constants, block/slice bundle types and the slice builder
//           for the Snappy slice distributor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package slice_pkg;

    localparam int BLOCK_BYTES     = 16;
    localparam int LOOKAHEAD_BYTES = 2;
    localparam int SLICE_BYTES     = 18;
    localparam int NUM_PARSER      = 6;
    localparam int ADDR_W          = 17;

    typedef struct packed {
        logic [SLICE_BYTES*8-1:0] data;
        logic [BLOCK_BYTES-1:0]   token_pos;
        logic [ADDR_W-1:0]        address;
        logic [2:0]               garbage;
        logic                     start_lit;
    } slice_t;

    typedef struct packed {
        logic [BLOCK_BYTES*8-1:0] data;
        logic [BLOCK_BYTES-1:0]   token_pos;
        logic [2:0]               garbage;
        logic                     start_lit;
        logic                     last;
    } blk_t;

    function automatic slice_t make_slice(input blk_t                       b,
                                          input logic [LOOKAHEAD_BYTES*8-1:0] la,
                                          input logic [ADDR_W-1:0]            addr);
        slice_t s;
        s.data      = {b.data, la};
        s.token_pos = b.token_pos;
        s.address   = addr;
        s.garbage   = b.garbage;
        s.start_lit = b.start_lit;
        return s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/slice_rr_dispatch.sv
// ============================================================================
// Module  : slice_rr_dispatch
// Brief   : Pending-slice register with strict round-robin one-hot dispatch.
//           Optional stall counter under SLICE_DIST_STALL_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_rr_dispatch
    import slice_pkg::*;
#(
    parameter int NUM_PARSER = slice_pkg::NUM_PARSER
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  slice_t                slice_i,
    input  logic [NUM_PARSER-1:0] parser_ready_i,
    output logic                  pend_free_o,
    output slice_t                slice_o,
    output logic [NUM_PARSER-1:0] valid_o
`ifdef SLICE_DIST_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt_o
`endif
);

    localparam int RR_W = $clog2(NUM_PARSER);

    slice_t                pend_q,  pend_d;
    logic                  pend_v_q, pend_v_d;
    logic [RR_W-1:0]       rr_q,    rr_d;
    slice_t                out_q,   out_d;
    logic [NUM_PARSER-1:0] valid_q, valid_d;
    logic                  dispatch;

    assign dispatch    = pend_v_q & parser_ready_i[rr_q];
    assign pend_free_o = ~pend_v_q | dispatch;

    // A load may land in the same cycle the current slice leaves.
    always_comb begin
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        rr_d     = rr_q;
        out_d    = out_q;
        valid_d  = '0;
        if (dispatch) begin
            out_d    = pend_q;
            valid_d  = NUM_PARSER'(1) << rr_q;
            rr_d     = (rr_q == RR_W'(NUM_PARSER - 1)) ? '0 : rr_q + 1'b1;
            pend_v_d = 1'b0;
        end
        if (load_i) begin
            pend_d   = slice_i;
            pend_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            rr_q     <= '0;
            out_q    <= '0;
            valid_q  <= '0;
        end else begin
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            rr_q     <= rr_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
        end
    end

    assign slice_o = out_q;
    assign valid_o = valid_q;

`ifdef SLICE_DIST_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (pend_v_q && !parser_ready_i[rr_q] && !(&stall_cnt_q)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

`default_nettype wire

// File: rtl/slice_distributor.sv
// ============================================================================
// Module  : slice_distributor
// Brief   : Builds 18-byte overlapping slices from 16-byte Snappy blocks and
//           hands them round-robin to the parser array.
//           Define SLICE_DIST_STALL_CNT_EN to add the stall_cnt output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module slice_distributor
    import slice_pkg::*;
#(
    parameter int NUM_PARSER = slice_pkg::NUM_PARSER,
    parameter int ADDR_W     = slice_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [127:0]          in_data,
    input  logic [15:0]           in_token_pos,
    input  logic                  in_start_lit,
    input  logic [2:0]            in_garbage,
    input  logic                  in_last,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_PARSER-1:0] parser_ready,
    output logic [143:0]          data_out,
    output logic [15:0]           token_pos,
    output logic [ADDR_W-1:0]     address,
    output logic [2:0]            garbage,
    output logic                  start_lit,
    output logic [NUM_PARSER-1:0] valid
`ifdef SLICE_DIST_STALL_CNT_EN
    ,
    output logic [31:0]           stall_cnt
`endif
);

    blk_t              hold_q,   hold_d;
    logic              hold_v_q, hold_v_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    blk_t              in_blk;
    slice_t            build_slice, slice_out;
    logic              build, build_last, accept, pend_free;

    assign in_blk   = {in_data, in_token_pos, in_garbage, in_start_lit, in_last};
    assign in_ready = rst_n & (~hold_v_q | pend_free);
    assign accept   = in_valid & in_ready;

    // A held last block owns the next free pending slot before anything else;
    // an arriving last block with no predecessor builds straight away.
    always_comb begin
        build       = 1'b0;
        build_last  = 1'b0;
        build_slice = '0;
        hold_d      = hold_q;
        hold_v_d    = hold_v_q;
        if (hold_v_q && hold_q.last) begin
            if (pend_free) begin
                build       = 1'b1;
                build_last  = 1'b1;
                build_slice = make_slice(hold_q, 16'h0000, addr_q);
                hold_v_d    = 1'b0;
            end
            if (accept) begin
                hold_d   = in_blk;
                hold_v_d = 1'b1;
            end
        end else if (hold_v_q) begin
            if (accept) begin
                build       = 1'b1;
                build_slice = make_slice(hold_q, in_data[127:112], addr_q);
                hold_d      = in_blk;
            end
        end else if (accept) begin
            if (in_last && pend_free) begin
                build       = 1'b1;
                build_last  = 1'b1;
                build_slice = make_slice(in_blk, 16'h0000, addr_q);
            end else begin
                hold_d   = in_blk;
                hold_v_d = 1'b1;
            end
        end
    end

    always_comb begin
        addr_d = addr_q;
        if (build) begin
            addr_d = build_last ? '0 : addr_q + ADDR_W'(BLOCK_BYTES);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            addr_q   <= '0;
        end else begin
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            addr_q   <= addr_d;
        end
    end

    slice_rr_dispatch #(
        .NUM_PARSER (NUM_PARSER)
    ) u_dispatch (
        .clk            (clk),
        .rst_n          (rst_n),
        .load_i         (build),
        .slice_i        (build_slice),
        .parser_ready_i (parser_ready),
        .pend_free_o    (pend_free),
        .slice_o        (slice_out),
        .valid_o        (valid)
`ifdef SLICE_DIST_STALL_CNT_EN
        ,
        .stall_cnt_o    (stall_cnt)
`endif
    );

    assign data_out  = slice_out.data;
    assign token_pos = slice_out.token_pos;
    assign address   = slice_out.address;
    assign garbage   = slice_out.garbage;
    assign start_lit = slice_out.start_lit;

endmodule

`default_nettype wire
